// File: rtl/count_reload_ctrl_pkg.sv
// count_reload_pkg: shared types and constants for the reload controller slice.
//   DEF_WIDTH    default counter data width
//   DEF_ENTRY_W  default request entry width, entry packed as {start, term}
//   state_t      controller FSM states (2-bit encoding)
package count_reload_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_ENTRY_W = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_reload_ctrl_if.sv
// count_reload_ctrl_if: segment request handshake.
//   IN_VALID  request valid                (master -> slave)
//   IN_START  segment start value          (master -> slave)
//   IN_TERM   segment terminal value       (master -> slave)
//   IN_READY  request can be accepted      (slave -> master)
interface count_reload_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_START;
  logic [WIDTH-1:0] IN_TERM;

  modport master (output IN_VALID, output IN_START, output IN_TERM, input IN_READY);
  modport slave  (input IN_VALID, input IN_START, input IN_TERM, output IN_READY);
endinterface

// File: rtl/count_reload_ctrl_reload_fifo.sv
// reload_fifo: DEPTH x DW synchronous FIFO with show-ahead read.
//   CLK, RESET   clock, asynchronous active-low reset (pointers and level only)
//   push, pop    write / read strobes; caller never pushes when full
//   wdata        entry to write
//   rdata        current head, valid whenever empty is low
//   full, empty  occupancy flags
//   level        occupancy 0..DEPTH
module reload_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Pointers wrap naturally at DEPTH; simultaneous push and pop keep level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

endmodule

// File: rtl/count_reload_ctrl.sv
// count_reload_ctrl: sequencer for an 8-bit reloadable up counter.
// Buffers {start, term} segment requests, then per segment loads start,
// enables counting until COUNT == term and pulses DONE.
//   CLK, RESET      clock, asynchronous active-low reset (shared with counter)
//   req             request handshake (slave side)
//   HOLD            pause counting while high (ignored in the load cycle)
//   COUNT           counter output fed back
//   CNT_LOAD/ENA    counter LOAD / ENA
//   CNT_DATA        counter DATA (start value during load, else 0)
//   DONE            one-cycle pulse at segment end
//   BUSY            segment in progress or requests pending
//   LEVEL           request FIFO occupancy
module count_reload_ctrl
  import count_reload_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  count_reload_ctrl_if.slave  req,
  input  logic                HOLD,
  input  logic [WIDTH-1:0]    COUNT,
  output logic                CNT_LOAD,
  output logic                CNT_ENA,
  output logic [WIDTH-1:0]    CNT_DATA,
  output logic                DONE,
  output logic                BUSY,
  output logic [AW:0]         LEVEL
);

  localparam int ENTRY_W = 2 * WIDTH;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   term_reg;
  logic [ENTRY_W-1:0] head;
  logic [WIDTH-1:0]   head_start;
  logic [WIDTH-1:0]   head_term;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  // Ready depends only on the registered level, so a full FIFO stalls the
  // producer even in the cycle where the head is being popped.
  assign req.IN_READY = !fifo_full;
  assign push         = req.IN_VALID && !fifo_full;
  assign pop          = (state == S_LOAD);

  reload_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .wdata ({req.IN_START, req.IN_TERM}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  assign {head_start, head_term} = head;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      term_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD) term_reg <= head_term;
    end
  end

  // Moore outputs except CNT_ENA in RUN, which follows COUNT and HOLD.
  // A terminal match ends the segment even while HOLD is high.
  always_comb begin
    state_nxt = state;
    CNT_LOAD  = 1'b0;
    CNT_ENA   = 1'b0;
    CNT_DATA  = '0;
    DONE      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        CNT_LOAD  = 1'b1;
        CNT_ENA   = 1'b1;
        CNT_DATA  = head_start;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        CNT_ENA = (COUNT != term_reg) && !HOLD;
        if (COUNT == term_reg) state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = fifo_empty ? S_IDLE : S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign BUSY = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_count_reload_ctrl.sv
// tb_count_reload_ctrl: drives count_reload_ctrl together with an 8-bit
// reloadable counter, checks every cycle against a queue-based model and
// pins the model with hand-computed expectations.
module tb_count_reload_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             HOLD = 1'b0;
  logic [WIDTH-1:0] COUNT;
  logic             CNT_LOAD;
  logic             CNT_ENA;
  logic [WIDTH-1:0] CNT_DATA;
  logic             DONE;
  logic             BUSY;
  logic [AW:0]      LEVEL;

  count_reload_ctrl_if #(.WIDTH(WIDTH)) req ();

  count_reload_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (req),
    .HOLD     (HOLD),
    .COUNT    (COUNT),
    .CNT_LOAD (CNT_LOAD),
    .CNT_ENA  (CNT_ENA),
    .CNT_DATA (CNT_DATA),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .LEVEL    (LEVEL)
  );

  always #5 CLK = ~CLK;

  // The controlled counter: load has priority over enable, cleared by RESET.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET)        COUNT <= '0;
    else if (CNT_LOAD) COUNT <= CNT_DATA;
    else if (CNT_ENA)  COUNT <= COUNT + 8'd1;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [7:0] s; logic [7:0] t; } seg_t;
  seg_t       mq[$];
  int         mphase = 0;      // 0 waiting, 1 loading, 2 counting, 3 finishing
  logic [7:0] mterm  = '0;
  logic [7:0] mcount = '0;
  bit         mpush;
  seg_t       mnew;

  initial forever begin
    @(posedge CLK or negedge RESET);
    if (!RESET) begin
      mq.delete();
      mphase = 0;
      mterm  = '0;
      mcount = '0;
    end else begin
      mpush = req.IN_VALID && (mq.size() < DEPTH);
      mnew  = '{s: req.IN_START, t: req.IN_TERM};
      case (mphase)
        0: if (mq.size() != 0) mphase = 1;
        1: begin
          mcount = mq[0].s;
          mterm  = mq[0].t;
          void'(mq.pop_front());
          mphase = 2;
        end
        2: begin
          if (mcount == mterm) mphase = 3;
          else if (!HOLD) mcount = mcount + 8'd1;
        end
        default: mphase = (mq.size() != 0) ? 1 : 0;
      endcase
      if (mpush) mq.push_back(mnew);
    end
  end

  // Per-cycle comparison against the model.
  logic [7:0] e_data;
  bit         e_ena;
  initial forever begin
    @(negedge CLK);
    #1;
    if (RESET) begin
      e_data = (mphase == 1 && mq.size() != 0) ? mq[0].s : 8'd0;
      e_ena  = (mphase == 1) || (mphase == 2 && mcount != mterm && !HOLD);
      chk("m_load",  32'(CNT_LOAD),     32'(mphase == 1));
      chk("m_ena",   32'(CNT_ENA),      32'(e_ena));
      chk("m_data",  32'(CNT_DATA),     32'(e_data));
      chk("m_done",  32'(DONE),         32'(mphase == 3));
      chk("m_busy",  32'(BUSY),         32'(mphase != 0 || mq.size() != 0));
      chk("m_level", 32'(LEVEL),        32'(mq.size()));
      chk("m_ready", 32'(req.IN_READY), 32'(mq.size() != DEPTH));
      chk("m_count", 32'(COUNT),        32'(mcount));
    end
  end

  // ---------------- event recorders ----------------
  int         ncyc = 0;
  int         done_n = 0;
  int         b2b_n = 0;
  bit         prev_done = 1'b0;
  logic [7:0] load_log[$];

  initial forever begin
    @(posedge CLK);
    ncyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      if (DONE) done_n++;
      if (CNT_LOAD) begin
        load_log.push_back(CNT_DATA);
        if (prev_done) b2b_n++;
      end
      prev_done = DONE;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_req(input logic [7:0] s, input logic [7:0] t, input int maxc);
    int   k = 0;
    logic r;
    req.IN_VALID = 1'b1;
    req.IN_START = s;
    req.IN_TERM  = t;
    r = req.IN_READY;
    while (!r && k < maxc) begin
      @(negedge CLK);
      r = req.IN_READY;
      k++;
    end
    chk("push_ready", 32'(r), 32'd1);
    @(posedge CLK);
    #2 req.IN_VALID = 1'b0;
  endtask

  task automatic wait_load(input int maxc);
    int k = 0;
    @(negedge CLK);
    while (CNT_LOAD !== 1'b1 && k < maxc) begin @(negedge CLK); k++; end
    chk("load_seen", 32'(CNT_LOAD), 32'd1);
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    @(negedge CLK);
    while (DONE !== 1'b1 && k < maxc) begin @(negedge CLK); k++; end
    chk("done_seen", 32'(DONE), 32'd1);
  endtask

  task automatic wait_count(input logic [7:0] v, input int maxc);
    int k = 0;
    @(negedge CLK);
    while (COUNT !== v && k < maxc) begin @(negedge CLK); k++; end
    chk("count_reach", 32'(COUNT), 32'(v));
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && k < maxc) begin @(negedge CLK); k++; end
    chk("idle_reach", 32'(BUSY), 32'd0);
  endtask

  // {10,15} from idle: load two cycles after the handshake, 6 run cycles.
  task automatic basic_seg(input string tag);
    int t_load;
    push_req(8'd10, 8'd15, 10);
    @(negedge CLK);
    chk({tag, "_lvl1"}, 32'(LEVEL), 32'd1);
    chk({tag, "_noload"}, 32'(CNT_LOAD), 32'd0);
    @(negedge CLK);
    chk({tag, "_load"}, 32'(CNT_LOAD), 32'd1);
    chk({tag, "_data"}, 32'(CNT_DATA), 32'd10);
    t_load = ncyc;
    @(negedge CLK);
    chk({tag, "_cnt10"}, 32'(COUNT), 32'd10);
    wait_done(40);
    chk({tag, "_run"}, 32'(ncyc - t_load - 1), 32'd6);
    chk({tag, "_cnt15"}, 32'(COUNT), 32'd15);
    @(negedge CLK);
    chk({tag, "_done_end"}, 32'(DONE), 32'd0);
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    chk({tag, "_hold15"}, 32'(COUNT), 32'd15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  int t0;
  int d0;

  initial begin
    req.IN_VALID = 1'b0;
    req.IN_START = '0;
    req.IN_TERM  = '0;

    // Reset state
    #7;
    chk("rst_load",  32'(CNT_LOAD), 32'd0);
    chk("rst_ena",   32'(CNT_ENA),  32'd0);
    chk("rst_data",  32'(CNT_DATA), 32'd0);
    chk("rst_done",  32'(DONE),     32'd0);
    chk("rst_busy",  32'(BUSY),     32'd0);
    chk("rst_level", 32'(LEVEL),    32'd0);
    @(posedge CLK);
    #2 RESET = 1'b1;
    @(negedge CLK);
    chk("rel_ready", 32'(req.IN_READY), 32'd1);
    chk("rel_busy",  32'(BUSY),         32'd0);
    @(posedge CLK);
    #2;

    // Basic
    basic_seg("basic");

    // Wrap {250,3}: 10 run cycles, one DONE
    @(posedge CLK); #2;
    d0 = done_n;
    push_req(8'd250, 8'd3, 10);
    wait_load(10);
    chk("wrap_data", 32'(CNT_DATA), 32'd250);
    t0 = ncyc;
    wait_done(40);
    chk("wrap_run", 32'(ncyc - t0 - 1), 32'd10);
    chk("wrap_cnt", 32'(COUNT), 32'd3);
    repeat (3) @(negedge CLK);
    chk("wrap_ndone", 32'(done_n - d0), 32'd1);

    // Equal {7,7}
    @(posedge CLK); #2;
    push_req(8'd7, 8'd7, 10);
    wait_load(10);
    t0 = ncyc;
    @(negedge CLK);
    chk("eq_ena", 32'(CNT_ENA), 32'd0);
    chk("eq_cnt", 32'(COUNT), 32'd7);
    wait_done(10);
    chk("eq_run", 32'(ncyc - t0 - 1), 32'd1);
    @(negedge CLK);
    chk("eq_cnt_after", 32'(COUNT), 32'd7);

    // Hold {0,20}: 5 frozen cycles at 8, HOLD high at terminal
    @(posedge CLK); #2;
    push_req(8'd0, 8'd20, 10);
    wait_load(10);
    t0 = ncyc;
    wait_count(8'd8, 40);
    HOLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_cnt", 32'(COUNT), 32'd8);
      chk("hold_ena", 32'(CNT_ENA), 32'd0);
    end
    HOLD = 1'b0;
    wait_count(8'd20, 40);
    HOLD = 1'b1;
    wait_done(5);
    chk("hold_run", 32'(ncyc - t0 - 1), 32'd26);
    HOLD = 1'b0;
    wait_idle(10);

    // Simultaneous push/pop, then back-pressure chain
    @(posedge CLK); #2;
    push_req(8'd0, 8'd5, 10);
    push_req(8'd100, 8'd140, 10);
    wait_load(20);
    wait_load(40);
    chk("chain_first", 32'(CNT_DATA), 32'd100);
    push_req(8'd20, 8'd21, 1);
    load_log.delete();
    d0 = done_n;
    b2b_n = 0;
    @(negedge CLK);
    chk("pushpop_lvl", 32'(LEVEL), 32'd1);
    @(posedge CLK); #2;
    push_req(8'd1, 8'd2, 10);
    push_req(8'd3, 8'd3, 10);
    push_req(8'd250, 8'd1, 10);
    req.IN_VALID = 1'b1;
    req.IN_START = 8'd9;
    req.IN_TERM  = 8'd12;
    @(negedge CLK);
    chk("bp_level", 32'(LEVEL), 32'd4);
    chk("bp_ready", 32'(req.IN_READY), 32'd0);
    push_req(8'd9, 8'd12, 80);
    wait_idle(200);
    chk("chain_ndone", 32'(done_n - d0), 32'd6);
    chk("chain_b2b", 32'(b2b_n), 32'd5);
    chk("chain_nload", 32'(load_log.size()), 32'd5);
    if (load_log.size() == 5) begin
      chk("order0", 32'(load_log[0]), 32'd20);
      chk("order1", 32'(load_log[1]), 32'd1);
      chk("order2", 32'(load_log[2]), 32'd3);
      chk("order3", 32'(load_log[3]), 32'd250);
      chk("order4", 32'(load_log[4]), 32'd9);
    end

    // Reset mid-RUN with 2 entries queued
    @(posedge CLK); #2;
    push_req(8'd0, 8'd50, 10);
    push_req(8'd60, 8'd61, 10);
    push_req(8'd70, 8'd71, 10);
    wait_count(8'd10, 40);
    chk("pre_rst_lvl", 32'(LEVEL), 32'd2);
    d0 = done_n;
    #2 RESET = 1'b0;
    #1;
    chk("arst_load",  32'(CNT_LOAD), 32'd0);
    chk("arst_ena",   32'(CNT_ENA),  32'd0);
    chk("arst_data",  32'(CNT_DATA), 32'd0);
    chk("arst_done",  32'(DONE),     32'd0);
    chk("arst_busy",  32'(BUSY),     32'd0);
    chk("arst_level", 32'(LEVEL),    32'd0);
    chk("arst_count", 32'(COUNT),    32'd0);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    @(negedge CLK);
    chk("post_rst_busy",  32'(BUSY),         32'd0);
    chk("post_rst_ready", 32'(req.IN_READY), 32'd1);
    repeat (2) @(negedge CLK);
    chk("post_rst_nodone", 32'(done_n - d0), 32'd0);
    @(posedge CLK); #2;
    basic_seg("again");

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
